// File: rtl/load_pkg.sv
// Shared types and defaults for the load unit: FSM states, access sizes, widths.
package load_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int REG_AW_DEF = 5;
  localparam int OFF_W_DEF  = 16;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  typedef enum logic [2:0] {IDLE, ADDR, MEM_REQ, MEM_WAIT, WB, ERR} state_e;
endpackage

// File: rtl/load_align.sv
// Selects the byte/half lane from a little-endian read word and sign/zero extends it.
module load_align
  import load_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        addr_lo,
  input  logic [1:0]        size,
  input  logic              uns,
  output logic [DATA_W-1:0] result
);
  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = rdata[8*addr_lo +: 8];
    h = rdata[16*addr_lo[1] +: 16];
    case (size)
      SIZE_B:  result = {{(DATA_W-8){b[7] & ~uns}}, b};
      SIZE_H:  result = {{(DATA_W-16){h[15] & ~uns}}, h};
      default: result = rdata;
    endcase
  end
endmodule

// File: rtl/load_unit.sv
// Single-outstanding load: base+offset address, memory req/gnt/rvalid, align, write back.
// LOAD_UNIT_MISALIGN_CHECK_EN enables alignment/reserved-size checks and the ERR path.
module load_unit
  import load_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_AW = REG_AW_DEF,
  parameter int OFF_W  = OFF_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [REG_AW-1:0] req_base_reg,
  input  logic [REG_AW-1:0] req_dest_reg,
  input  logic [OFF_W-1:0]  req_offset,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  output logic [REG_AW-1:0] read_reg1,
  input  logic [DATA_W-1:0] reg_data1,
  output logic              mem_req,
  output logic [DATA_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              reg_write,
  output logic [REG_AW-1:0] write_reg,
  output logic [DATA_W-1:0] write_data,
  output logic              busy,
  output logic              load_err
);
  state_e            state, state_nxt;
  logic [REG_AW-1:0] base_q, dest_q;
  logic [OFF_W-1:0]  off_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [DATA_W-1:0] addr_q, data_q, eff_addr, aligned;
  logic              mis;

  assign eff_addr = reg_data1 + {{(DATA_W-OFF_W){off_q[OFF_W-1]}}, off_q};

`ifdef LOAD_UNIT_MISALIGN_CHECK_EN
  always_comb begin
    case (size_q)
      SIZE_B:  mis = 1'b0;
      SIZE_H:  mis = eff_addr[0];
      SIZE_W:  mis = |eff_addr[1:0];
      default: mis = 1'b1;
    endcase
  end
  assign mem_addr = addr_q;
`else
  assign mis      = 1'b0;
  // Memory sees a word-aligned address; lane select below still uses addr_q[1:0].
  assign mem_addr = {addr_q[DATA_W-1:2], 2'b00};
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (req_valid)  state_nxt = ADDR;
      ADDR:     state_nxt = mis ? ERR : MEM_REQ;
      MEM_REQ:  if (mem_gnt)    state_nxt = MEM_WAIT;
      MEM_WAIT: if (mem_rvalid) state_nxt = WB;
      WB:       state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == IDLE);
    busy      = (state != IDLE);
    mem_req   = (state == MEM_REQ);
    reg_write = (state == WB) && (dest_q != '0);
`ifdef LOAD_UNIT_MISALIGN_CHECK_EN
    load_err  = (state == ERR);
`else
    load_err  = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      base_q <= '0;
      dest_q <= '0;
      off_q  <= '0;
      size_q <= '0;
      uns_q  <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      if (state == IDLE && req_valid) begin
        base_q <= req_base_reg;
        dest_q <= req_dest_reg;
        off_q  <= req_offset;
        size_q <= req_size;
        uns_q  <= req_unsigned;
      end
      if (state == ADDR) addr_q <= eff_addr;
      if (state == MEM_WAIT && mem_rvalid) data_q <= aligned;
    end
  end

  load_align #(.DATA_W(DATA_W)) u_align (
    .rdata   (mem_rdata),
    .addr_lo (addr_q[1:0]),
    .size    (size_q),
    .uns     (uns_q),
    .result  (aligned)
  );

  assign read_reg1  = base_q;
  assign write_reg  = dest_q;
  assign write_data = data_q;
endmodule

// File: tb/tb_load_unit.sv
// Directed bench for load_unit with a transaction-level reference model and a per-cycle monitor.
module tb_load_unit;
  import load_pkg::*;

`ifdef LOAD_UNIT_MISALIGN_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0, req_ready;
  logic [4:0]  req_base_reg = '0, req_dest_reg = '0;
  logic [15:0] req_offset = '0;
  logic [1:0]  req_size = '0;
  logic        req_unsigned = 1'b0;
  logic [4:0]  read_reg1;
  logic [31:0] reg_data1;
  logic        mem_req, mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic [31:0] mem_addr, mem_rdata = '0;
  logic        reg_write, busy, load_err;
  logic [4:0]  write_reg;
  logic [31:0] write_data;

  logic [31:0] rf [32];
  assign reg_data1 = rf[read_reg1];

  always #5 clk = ~clk;

  load_unit dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_base_reg(req_base_reg), .req_dest_reg(req_dest_reg), .req_offset(req_offset),
    .req_size(req_size), .req_unsigned(req_unsigned), .read_reg1(read_reg1),
    .reg_data1(reg_data1), .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .reg_write(reg_write),
    .write_reg(write_reg), .write_data(write_data), .busy(busy), .load_err(load_err)
  );

  int n_cmp = 0, n_bad = 0;
  int writes_seen = 0, errs_seen = 0, req_seen = 0;
  logic [31:0] exp_addr = '0, exp_data = '0;
  logic [4:0]  exp_dest = '0;
  bit mon_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic chb(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%b required=%b", nm, act, exp);
    end
  endtask

  // Reference model: effective address, error rule, and extracted value.
  function automatic logic [31:0] m_ea(input logic [31:0] base, input logic [15:0] off);
    return base + 32'(int'($signed(off)));
  endfunction

  function automatic bit m_err(input logic [31:0] a, input logic [1:0] sz);
    if (!CHK) return 1'b0;
    if (sz == 2'd3) return 1'b1;
    if (sz == SIZE_H) return (a % 2) != 0;
    if (sz == SIZE_W) return (a % 4) != 0;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_data(input logic [31:0] a, input logic [1:0] sz,
                                         input bit uns, input logic [31:0] rd);
    int lane;
    logic [31:0] v;
    lane = int'(a % 4);
    if (sz == SIZE_B) begin
      v = (rd >> (8*lane)) & 32'hFF;
      if (!uns && v >= 32'h80) v = v + 32'hFFFFFF00;
    end else if (sz == SIZE_H) begin
      v = (rd >> (16*(lane/2))) & 32'hFFFF;
      if (!uns && v >= 32'h8000) v = v + 32'hFFFF0000;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  always @(negedge clk) begin
    if (mon_en && !reset) begin
      chb("ready_vs_busy", req_ready, !busy);
      if (mem_req) begin
        req_seen++;
        chk("mem_addr", mem_addr, exp_addr);
      end
      if (reg_write) begin
        writes_seen++;
        chk("write_reg", {27'b0, write_reg}, {27'b0, exp_dest});
        chk("write_data", write_data, exp_data);
      end
      if (load_err) errs_seen++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outs(input string tag);
    chb({tag, "_ready"}, req_ready, 1'b1);
    chb({tag, "_busy"}, busy, 1'b0);
    chb({tag, "_mem_req"}, mem_req, 1'b0);
    chk({tag, "_mem_addr"}, mem_addr, 32'h0);
    chb({tag, "_reg_write"}, reg_write, 1'b0);
    chk({tag, "_write_reg"}, {27'b0, write_reg}, 32'h0);
    chk({tag, "_write_data"}, write_data, 32'h0);
    chk({tag, "_read_reg1"}, {27'b0, read_reg1}, 32'h0);
    chb({tag, "_load_err"}, load_err, 1'b0);
  endtask

  task automatic run_load(input logic [4:0] breg, input logic [31:0] bval, input logic [4:0] dest,
                          input logic [15:0] off, input logic [1:0] sz, input bit uns,
                          input logic [31:0] rdata, input int gw, input int rw, input bit stale,
                          input logic [31:0] lit_data, input bit use_lit);
    logic [31:0] a;
    bit err;
    int cyc;
    rf[breg] = bval;
    a = m_ea(bval, off);
    err = m_err(a, sz);
    exp_addr = CHK ? a : (a & ~32'h3);
    exp_data = m_data(a, sz, uns, rdata);
    exp_dest = dest;
    if (use_lit) chk("model_pin", exp_data, lit_data);
    writes_seen = 0; errs_seen = 0; req_seen = 0;
    chb("ready_idle", req_ready, 1'b1);
    req_valid = 1'b1; req_base_reg = breg; req_dest_reg = dest;
    req_offset = off; req_size = sz; req_unsigned = uns;
    tick(); cyc = 1;
    req_valid = 1'b0;
    chb("ready_drop", req_ready, 1'b0);
    chb("addr_no_req", mem_req, 1'b0);
    tick(); cyc++;
    if (err) begin
      chb("err_pulse", load_err, 1'b1);
      chb("err_no_req", mem_req, 1'b0);
      tick();
      chb("err_ready", req_ready, 1'b1);
      chb("err_cleared", load_err, 1'b0);
      chk("err_count", errs_seen, 1);
      chk("err_no_write", writes_seen, 0);
      chk("err_no_mem", req_seen, 0);
    end else begin
      chb("no_err", load_err, 1'b0);
      for (int i = 0; i < gw; i++) begin
        chb("req_hold", mem_req, 1'b1);
        mem_rvalid = stale && (i == 0);
        mem_rdata = ~rdata;
        tick(); cyc++;
      end
      mem_rvalid = 1'b0;
      chb("req_at_gnt", mem_req, 1'b1);
      mem_gnt = 1'b1;
      tick(); cyc++;
      mem_gnt = 1'b0;
      chb("req_drop", mem_req, 1'b0);
      for (int i = 0; i < rw; i++) begin
        chb("no_early_wr", reg_write, 1'b0);
        tick(); cyc++;
      end
      mem_rvalid = 1'b1; mem_rdata = rdata;
      tick(); cyc++;
      mem_rvalid = 1'b0; mem_rdata = '0;
      chb("wb_we", reg_write, dest != 5'd0);
      chk("wb_data", write_data, exp_data);
      if (use_lit) chk("wb_lit", write_data, lit_data);
      chb("wb_busy", busy, 1'b1);
      if (gw == 0 && rw == 0) chk("latency", cyc, 4);
      tick();
      chb("back_ready", req_ready, 1'b1);
      chb("idle_no_we", reg_write, 1'b0);
      chk("write_count", writes_seen, (dest != 5'd0) ? 1 : 0);
      chk("req_cycles", req_seen, gw + 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'h0;
    tick(); tick();
    reset = 1'b0;
    chk_reset_outs("reset");
    mon_en = 1'b1;

    // Pin the model against hand-computed values.
    chk("ea_pin_word", m_ea(32'h1000, 16'd4), 32'h0000_1004);
    chk("ea_pin_neg", m_ea(32'h1000, 16'hFFFE), 32'h0000_0FFE);
    chk("ea_pin_wrap", m_ea(32'hFFFF_FFFC, 16'd8), 32'h0000_0004);

    // A response arriving while idle must be dropped.
    mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    tick();
    mem_rvalid = 1'b0;
    chb("idle_rvalid_busy", busy, 1'b0);
    chb("idle_rvalid_we", reg_write, 1'b0);

    run_load(5'd2, 32'h1000, 5'd5, 16'd4, SIZE_W, 1'b0, 32'hDEADBEEF, 0, 0, 1'b0, 32'hDEADBEEF, 1'b1);
    run_load(5'd2, 32'h1000, 5'd6, 16'd3, SIZE_B, 1'b0, 32'h80FFFFFF, 0, 1, 1'b0, 32'hFFFFFF80, 1'b1);
    run_load(5'd2, 32'h1000, 5'd6, 16'd3, SIZE_B, 1'b1, 32'h80FFFFFF, 0, 0, 1'b0, 32'h00000080, 1'b1);
    run_load(5'd2, 32'h1000, 5'd9, 16'hFFFE, SIZE_H, 1'b0, 32'hCAFE1234, 3, 5, 1'b1, 32'hFFFFCAFE, 1'b1);
    run_load(5'd2, 32'h1000, 5'd10, 16'd2, SIZE_W, 1'b0, 32'h11223344, 0, 0, 1'b0, 32'h11223344, !CHK);
    run_load(5'd2, 32'h1000, 5'd11, 16'd0, 2'd3, 1'b0, 32'hA5A50F0F, 0, 0, 1'b0, 32'hA5A50F0F, !CHK);
    run_load(5'd2, 32'h1000, 5'd0, 16'd8, SIZE_W, 1'b0, 32'h0BADF00D, 1, 2, 1'b0, 32'h0BADF00D, 1'b1);
    run_load(5'd3, 32'h2000, 5'd12, 16'd0, SIZE_H, 1'b1, 32'h1234ABCD, 0, 0, 1'b0, 32'h0000ABCD, 1'b1);
    run_load(5'd4, 32'hFFFFFFFC, 5'd13, 16'd8, SIZE_W, 1'b0, 32'h01020304, 2, 0, 1'b0, 32'h01020304, 1'b1);
    run_load(5'd2, 32'h1000, 5'd14, 16'd1, SIZE_B, 1'b0, 32'h00007F00, 0, 0, 1'b0, 32'h0000007F, 1'b1);

    // Reset while waiting for data: the late response must not write back.
    rf[2] = 32'h1000;
    exp_addr = 32'h1000; exp_dest = 5'd7; exp_data = 32'h0;
    writes_seen = 0;
    req_valid = 1'b1; req_base_reg = 5'd2; req_dest_reg = 5'd7;
    req_offset = 16'd0; req_size = SIZE_W; req_unsigned = 1'b0;
    tick();
    req_valid = 1'b0;
    tick();
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    chb("wait_busy", busy, 1'b1);
    chb("wait_no_req", mem_req, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_reset_outs("abort");
    mem_rvalid = 1'b1; mem_rdata = 32'h55AA55AA;
    tick();
    mem_rvalid = 1'b0;
    chb("stale_no_we", reg_write, 1'b0);
    chb("stale_idle", busy, 1'b0);
    tick();
    chk("stale_write_count", writes_seen, 0);
    chb("stale_ready", req_ready, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/load_unit.md
Name: load_unit

Overview:
- Executes one load instruction at a time for the execution-cycle datapath.
- Reads the base register through a register-file read port and forms the effective address as base + sign-extended offset.
- Fetches the data from data memory over a req/gnt/rvalid handshake, then aligns and extends it.
- Drives the register-file write port (reg_write/write_reg/write_data) for one cycle to write back the result.
- Sits between decode/issue and register_file; it is the write-side initiator on the register-file interface.

Parameters:
- DATA_W, 32, register and memory data width.
- REG_AW, 5, register index width.
- OFF_W, 16, immediate offset width; sign-extended to DATA_W.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  load request valid.
- req_ready  out  1  unit can accept a request; high only in IDLE.
- req_base_reg  in  REG_AW  base register index.
- req_dest_reg  in  REG_AW  destination register index.
- req_offset  in  OFF_W  signed byte offset.
- req_size  in  2  0=byte, 1=half, 2=word, 3=reserved.
- req_unsigned  in  1  1=zero-extend, 0=sign-extend.
- read_reg1  out  REG_AW  register-file read index.
- reg_data1  in  DATA_W  register-file read data (combinational).
- mem_req  out  1  memory read request.
- mem_addr  out  DATA_W  byte address.
- mem_gnt  in  1  memory accepted the request.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  DATA_W  read data word, little-endian.
- reg_write  out  1  register-file write enable.
- write_reg  out  REG_AW  register-file write index.
- write_data  out  DATA_W  register-file write data.
- busy  out  1  state != IDLE.
- load_err  out  1  one-cycle pulse on a rejected load.

Behaviour:
- Reset (synchronous): state=IDLE; all outputs 0 except req_ready=1. Reset aborts any operation in any state. No write occurs for an aborted load.
- IDLE:
  - req_ready=1.
  - On req_valid: latch base, dest, offset, size, unsigned; go to ADDR.
- read_reg1 always drives the latched base index.
- ADDR (1 cycle):
  - addr = reg_data1 + sext(offset), modulo 2^DATA_W (wraps, no overflow flag).
  - Check alignment: half needs addr[0]=0; word needs addr[1:0]=0; size=3 is always an error.
  - On error go to ERR; otherwise register mem_addr and go to MEM_REQ.
- MEM_REQ:
  - mem_req=1; mem_addr held stable until mem_gnt.
  - On mem_gnt go to MEM_WAIT.
  - mem_rvalid seen in MEM_REQ is ignored.
- MEM_WAIT:
  - Wait any number of cycles.
  - On mem_rvalid, capture aligned data and go to WB.
- Alignment:
  - byte = mem_rdata[8*addr[1:0] +: 8].
  - half = mem_rdata[16*addr[1] +: 16].
  - word passes through.
  - Extension is set by the latched unsigned flag.
- WB (1 cycle):
  - reg_write=1, with write_reg=dest and write_data=aligned data.
  - If dest==0: reg_write stays 0, write_data is still presented, and the FSM proceeds normally.
  - Go to IDLE.
- ERR (1 cycle): load_err=1, no memory access, no write; go to IDLE.
- Latency: accept at edge N, then ADDR N+1, MEM_REQ N+2 (gnt), MEM_WAIT N+3 (rvalid). reg_write is high during cycle N+4 at minimum.
- Throughput: one load per five or more cycles. No back-to-back accept; req_ready returns high the cycle after WB or ERR.
- A mem_rvalid seen in IDLE, ADDR or ERR (for example a stale response after reset) is dropped.

Optional Feature:
- Macro: LOAD_UNIT_MISALIGN_CHECK_EN.
- Defined: alignment and reserved-size checks are active as above, and ERR is reachable.
- Undefined:
  - No checks; ERR state and load_err logic are removed, and load_err is tied to 0.
  - mem_addr is force-aligned by clearing addr[1:0].
  - Lane select still uses the unaligned addr bits.
  - size=3 is treated as word.

Decomposition:
- Package load_pkg:
  - state enum (IDLE, ADDR, MEM_REQ, MEM_WAIT, WB, ERR).
  - size constants SIZE_B=2'd0, SIZE_H=2'd1, SIZE_W=2'd2.
  - DATA_W/REG_AW defaults.
- Sub-module load_align: combinational lane select plus sign/zero extension. Inputs are rdata, addr[1:0], size and unsigned; output is the DATA_W result.

Test Plan:
- Word load: r2=0x00001000, offset=4, size=W, dest=5, mem returns 0xDEADBEEF with gnt at once and rvalid the next cycle. Expect mem_addr=0x1004, then reg_write for one cycle with write_reg=5, write_data=0xDEADBEEF, 4 cycles after accept.
- Signed byte: r2=0x1000, offset=3, size=B, signed, rdata=0x80FFFFFF. Expect write_data=0xFFFFFF80. With unsigned=1, expect 0x00000080.
- Half and handshake: offset=-2 (0xFFFE), size=H, signed, rdata=0xCAFE1234. Expect mem_addr=0x0FFE and write_data=0xFFFFCAFE. Hold mem_gnt low for 3 cycles: mem_req and mem_addr stay stable. Delay rvalid 5 cycles: no early write.
- Misalign with CHECK_EN: word at 0x1002. Expect load_err for 1 cycle, mem_req never asserted, reg_write 0, req_ready back next cycle. Without CHECK_EN: mem_addr=0x1000 and the load completes.
- dest=0: full transaction completes, reg_write stays 0 throughout, req_ready returns.
- Reset in MEM_WAIT: assert reset for 1 cycle, then deliver mem_rvalid. Expect no reg_write, state IDLE, req_ready=1, all outputs 0.
